// File: rtl/xadc_drp_responder_if.sv
// DRP handshake bundle between a DRP initiator and the XADC stand-in responder.
interface xadc_drp_responder_if;
  logic        drp_den;
  logic        drp_dwe;
  logic [6:0]  drp_addr;
  logic [15:0] drp_din;
  logic [15:0] drp_dout;
  logic        drp_drdy;

  modport master (
    output drp_den, drp_dwe, drp_addr, drp_din,
    input  drp_dout, drp_drdy
  );

  modport slave (
    input  drp_den, drp_dwe, drp_addr, drp_din,
    output drp_dout, drp_drdy
  );
endinterface

// File: rtl/xadc_drp_responder.sv
// XADC stand-in: answers DRP reads/writes after a fixed latency, holds a
// measurement/config register map and generates the XADC alarm outputs.
//
// state | meaning
// IDLE  | no transaction in flight; den accepted (also during the drdy cycle)
// BUSY  | transaction latched, latency counter running
module xadc_drp_responder #(
  parameter int unsigned pLATENCY  = 4,
  parameter logic [15:0] pMEAS_RST = 16'h0000
) (
  input  logic                clk_usb,
  input  logic                reset_i,
  xadc_drp_responder_if.slave drp,
  input  logic                meas_wr,
  input  logic [1:0]          meas_sel,
  input  logic [15:0]         meas_data,
  output logic                ot_out,
  output logic                user_temp_alarm_out,
  output logic                vccint_alarm_out,
  output logic                vccaux_alarm_out,
  output logic                vbram_alarm_out,
  output logic                proto_err
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BUSY  = 1'b1;
  localparam logic [3:0] CNT_LOAD = 4'(pLATENCY - 1);
  // With latency 1 the transaction completes on the den edge itself.
  localparam bit         LAT_ONE  = (pLATENCY == 1);

  // measurement index: 0 temp, 1 vccint, 2 vccaux, 3 vbram
  logic [15:0] meas_q [4];
  logic [15:0] meas_d [4];
  logic [15:0] cfg_q  [64];
  logic [15:0] cfg_d  [64];

  logic [0:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [6:0]  addr_q, addr_d;
  logic        dwe_q, dwe_d;
  logic [15:0] din_q, din_d;
  logic [15:0] dout_q, dout_d;
  logic        drdy_q, drdy_d;
  logic        proto_err_q, proto_err_d;
  logic        ot_q, ot_d;
  logic        utemp_q, utemp_d;
  logic        vccint_q, vccint_d;
  logic        vccaux_q, vccaux_d;
  logic        vbram_q, vbram_d;

  logic        start;
  logic        complete;
  logic [6:0]  txn_addr;
  logic        txn_dwe;
  logic [15:0] txn_din;
  logic [15:0] rd_data;

  function automatic logic [15:0] cfg_rst_val(input logic [5:0] idx);
    case (idx)
      6'h10:   cfg_rst_val = 16'hB5ED;
      6'h14:   cfg_rst_val = 16'hA93A;
      6'h13:   cfg_rst_val = 16'hCA30;
      6'h17:   cfg_rst_val = 16'hAE4E;
      6'h11:   cfg_rst_val = 16'h5999;
      6'h15:   cfg_rst_val = 16'h5111;
      6'h12:   cfg_rst_val = 16'hA147;
      6'h16:   cfg_rst_val = 16'h91EB;
      6'h18:   cfg_rst_val = 16'h5999;
      6'h1C:   cfg_rst_val = 16'h5111;
      default: cfg_rst_val = 16'h0000;
    endcase
  endfunction

  // Handshake FSM: accept, count down, complete with a one-cycle drdy.
  always_comb begin
    start    = (state_q == ST_IDLE) && drp.drp_den;
    complete = LAT_ONE ? start : ((state_q == ST_BUSY) && (cnt_q == 4'd1));
    txn_addr = LAT_ONE ? drp.drp_addr : addr_q;
    txn_dwe  = LAT_ONE ? drp.drp_dwe  : dwe_q;
    txn_din  = LAT_ONE ? drp.drp_din  : din_q;

    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    dwe_d       = dwe_q;
    din_d       = din_q;
    drdy_d      = complete;
    proto_err_d = proto_err_q | (drp.drp_den && (state_q == ST_BUSY));

    if (state_q == ST_BUSY) begin
      cnt_d = cnt_q - 4'd1;
      if (complete) state_d = ST_IDLE;
    end

    if (start) begin
      addr_d  = drp.drp_addr;
      dwe_d   = drp.drp_dwe;
      din_d   = drp.drp_din;
      cnt_d   = CNT_LOAD;
      state_d = LAT_ONE ? ST_IDLE : ST_BUSY;
    end
  end

  // Register map read mux and the read/write/backdoor updates.
  always_comb begin
    rd_data = 16'h0000;
    if (txn_addr[6]) begin
      rd_data = cfg_q[txn_addr[5:0]];
    end else begin
      case (txn_addr[5:0])
        6'h00:   rd_data = meas_q[0];
        6'h01:   rd_data = meas_q[1];
        6'h02:   rd_data = meas_q[2];
        6'h06:   rd_data = meas_q[3];
        default: rd_data = 16'h0000;
      endcase
    end

    dout_d = dout_q;
    if (complete && !txn_dwe) dout_d = rd_data;

    meas_d = meas_q;
    if (meas_wr) meas_d[meas_sel] = meas_data;

    cfg_d = cfg_q;
    if (complete && txn_dwe && txn_addr[6]) cfg_d[txn_addr[5:0]] = txn_din;
  end

  // Alarm evaluation on bits [15:4]; temperature alarms have hysteresis.
  always_comb begin
    utemp_d = utemp_q;
    if (meas_q[0][15:4] > cfg_q[6'h10][15:4])      utemp_d = 1'b1;
    else if (meas_q[0][15:4] < cfg_q[6'h14][15:4]) utemp_d = 1'b0;

    ot_d = ot_q;
    if (meas_q[0][15:4] > cfg_q[6'h13][15:4])      ot_d = 1'b1;
    else if (meas_q[0][15:4] < cfg_q[6'h17][15:4]) ot_d = 1'b0;

    vccint_d = (meas_q[1][15:4] > cfg_q[6'h11][15:4]) | (meas_q[1][15:4] < cfg_q[6'h15][15:4]);
    vccaux_d = (meas_q[2][15:4] > cfg_q[6'h12][15:4]) | (meas_q[2][15:4] < cfg_q[6'h16][15:4]);
    vbram_d  = (meas_q[3][15:4] > cfg_q[6'h18][15:4]) | (meas_q[3][15:4] < cfg_q[6'h1C][15:4]);
  end

  // State registers with synchronous reset; reset also aborts any transaction.
  always_ff @(posedge clk_usb) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= 7'd0;
      dwe_q       <= 1'b0;
      din_q       <= 16'h0000;
      dout_q      <= 16'h0000;
      drdy_q      <= 1'b0;
      proto_err_q <= 1'b0;
      ot_q        <= 1'b0;
      utemp_q     <= 1'b0;
      vccint_q    <= 1'b0;
      vccaux_q    <= 1'b0;
      vbram_q     <= 1'b0;
      for (int i = 0; i < 4; i++)  meas_q[i] <= pMEAS_RST;
      for (int i = 0; i < 64; i++) cfg_q[i]  <= cfg_rst_val(6'(i));
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      dwe_q       <= dwe_d;
      din_q       <= din_d;
      dout_q      <= dout_d;
      drdy_q      <= drdy_d;
      proto_err_q <= proto_err_d;
      ot_q        <= ot_d;
      utemp_q     <= utemp_d;
      vccint_q    <= vccint_d;
      vccaux_q    <= vccaux_d;
      vbram_q     <= vbram_d;
      meas_q      <= meas_d;
      cfg_q       <= cfg_d;
    end
  end

  assign drp.drp_dout         = dout_q;
  assign drp.drp_drdy         = drdy_q;
  assign proto_err            = proto_err_q;
  assign ot_out               = ot_q;
  assign user_temp_alarm_out  = utemp_q;
  assign vccint_alarm_out     = vccint_q;
  assign vccaux_alarm_out     = vccaux_q;
  assign vbram_alarm_out      = vbram_q;

endmodule
